// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_arb_pkg
//  Description : Shared constants for the multiplier arbiter: FSM state
//                encoding and operand/product widths.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_arb_pkg;

    localparam int OPERAND_W = 8;
    localparam int PRODUCT_W = 16;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] CLEAR = 3'd1;
    localparam logic [STATE_W-1:0] START = 3'd2;
    localparam logic [STATE_W-1:0] WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] RESP  = 3'd4;

endpackage : mul_arb_pkg
`default_nettype wire

// File: rtl/mul_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant. Scans req starting at ptr,
//                wrapping at N_REQ, and returns the first set bit.
//  Ports       : req      - request vector
//                ptr      - highest-priority index (always < N_REQ)
//                grant    - one-hot grant, zero when no request
//                grant_id - encoded index of the granted bit
//                any_req  - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any_req
);

    logic w_found;
    int   w_idx;

    // Outer loop walks priority order (ptr, ptr+1, ...); the inner loop maps
    // that wrapped position back onto a constant bit index.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any_req  = |req;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && (i == w_idx) && req[i]) begin
                    w_found  = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = ID_W'(i);
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_arbiter
//  Description : Shares one 8x8 unsigned multiplier among N_REQ requesters
//                with round-robin arbitration. Each job clears the
//                multiplier, pulses start, waits for its sticky ready (bounded
//                by a watchdog) and returns the product over a valid/ready
//                response channel.
//  Ports       : clock, reset           - clock / sync active-high reset
//                req_valid/ready/x/y    - packed per-requester request channel
//                resp_valid/ready       - response handshake
//                resp_id/product/timeout- response payload
//                busy                   - high whenever not IDLE
//                mul_reset/start/x/y    - drive the shared multiplier
//                mul_ready/product      - results from the multiplier
//  Revision    : 1.0  initial release
// ============================================================================
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [8*N_REQ-1:0]     req_x,
    input  logic [8*N_REQ-1:0]     req_y,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [15:0]            resp_product,
    output logic                   resp_timeout,
    output logic                   busy,
    output logic                   mul_reset,
    output logic                   mul_start,
    output logic [7:0]             mul_x,
    output logic [7:0]             mul_y,
    input  logic                   mul_ready,
    input  logic [15:0]            mul_product
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] c_wdog_last = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]   c_last_id   = ID_W'(N_REQ - 1);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_next;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [WDOG_W-1:0]    r_wdog;

    logic [N_REQ-1:0]     w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic                 w_any_req;
    logic [OPERAND_W-1:0] w_sel_x;
    logic [OPERAND_W-1:0] w_sel_y;
    logic                 w_take_grant;
    logic                 w_timeout_hit;

    logic                 w_mul_reset_d;
    logic                 w_mul_start_d;
    logic                 w_busy_d;
    logic                 w_resp_valid_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (r_rr_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id),
        .any_req  (w_any_req)
    );

    // Operand select from the one-hot grant.
    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_x = req_x[i*OPERAND_W +: OPERAND_W];
                w_sel_y = req_y[i*OPERAND_W +: OPERAND_W];
            end
        end
    end

    assign w_take_grant  = (r_state == IDLE) && w_any_req;
    assign w_timeout_hit = (r_wdog == c_wdog_last);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = CLEAR;
            CLEAR:   w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT:    if (mul_ready || w_timeout_hit) w_state_next = RESP;
            RESP:    if (resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    // Control outputs are registered, so they are decoded from the next
    // state and line up exactly with the state they belong to.
    always_comb begin
        w_mul_reset_d  = (w_state_next == CLEAR);
        w_mul_start_d  = (w_state_next == START);
        w_busy_d       = (w_state_next != IDLE);
        w_resp_valid_d = (w_state_next == RESP);
        req_ready      = (r_state == IDLE) ? w_grant : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mul_reset    <= 1'b1;
            mul_start    <= 1'b0;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            mul_x        <= '0;
            mul_y        <= '0;
            resp_id      <= '0;
            resp_product <= '0;
            resp_timeout <= 1'b0;
            r_rr_ptr     <= '0;
            r_wdog       <= '0;
        end else begin
            mul_reset  <= w_mul_reset_d;
            mul_start  <= w_mul_start_d;
            busy       <= w_busy_d;
            resp_valid <= w_resp_valid_d;

            // Operands change only on a grant; the multiplier samples them
            // live for the whole job.
            if (w_take_grant) begin
                mul_x    <= w_sel_x;
                mul_y    <= w_sel_y;
                resp_id  <= w_grant_id;
                r_rr_ptr <= (w_grant_id == c_last_id) ? '0
                                                      : w_grant_id + ID_W'(1);
            end

            if (r_state == START) begin
                r_wdog <= '0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            // A ready seen on the last watchdog cycle still counts as success.
            if (r_state == WAIT) begin
                if (mul_ready) begin
                    resp_product <= mul_product;
                    resp_timeout <= 1'b0;
                end else if (w_timeout_hit) begin
                    resp_product <= '0;
                    resp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule : mul_arbiter
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_arbiter
//  Description : Self-checking bench for mul_arbiter with a behavioural
//                multiplier (programmable latency, hang option).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [1:0]  resp_id;
    logic [15:0] resp_product;
    logic        resp_timeout;
    logic        busy;
    logic        mul_reset;
    logic        mul_start;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic        mul_ready;
    logic [15:0] mul_product;

    mul_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .mul_reset    (mul_reset),
        .mul_start    (mul_start),
        .mul_x        (mul_x),
        .mul_y        (mul_y),
        .mul_ready    (mul_ready),
        .mul_product  (mul_product)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------- behavioural multiplier
    int          mul_lat = 4;
    bit          hang    = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_rdy   = 1'b0;
    int          m_cnt   = 0;
    logic [15:0] m_prod  = '0;

    always @(posedge clock) begin
        if (mul_reset) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_cnt  <= 0;
            m_prod <= '0;
        end else if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
        end else if (m_busy && !hang) begin
            if (m_cnt == mul_lat - 1) begin
                m_rdy  <= 1'b1;
                m_busy <= 1'b0;
                m_prod <= {8'b0, mul_x} * {8'b0, mul_y};
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end
    assign mul_ready   = m_rdy;
    assign mul_product = m_prod;

    // ---------------------------------------------- event counters (monotonic)
    int n_rdy = 0, n_mrst = 0, n_mstart = 0, n_wait = 0;
    always @(posedge clock) begin
        if (!reset) begin
            if (req_ready != 4'b0) n_rdy    <= n_rdy + 1;
            if (mul_reset)         n_mrst   <= n_mrst + 1;
            if (mul_start)         n_mstart <= n_mstart + 1;
            if (busy && !mul_reset && !mul_start && !resp_valid)
                n_wait <= n_wait + 1;
        end
    end

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic [1:0]  id;
        logic [15:0] p;
        logic        to;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          id;
        logic [7:0]  x;
        logic [7:0]  y;
        int          lat;
        bit          hng;
        logic [15:0] p;
        logic        to;
        int          wcyc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Wait at negedges until req_ready[id] is seen; the next posedge grants.
    task automatic wait_grant(input int id);
        int t = 0;
        #1;
        while (!req_ready[id] && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) chk("grant_wait_expired", 32'(req_ready), 32'(1 << id));
    endtask

    // Bounded wait for resp_valid, then pop and compare the expected result.
    task automatic wait_and_check(input string tag);
        int   t = 0;
        exp_t e;
        while (!resp_valid && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (t >= 300) begin
            chk({tag, "_resp_wait_expired"}, 32'(resp_valid), 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected_resp"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"},      32'(resp_id),      32'(e.id));
            chk({tag, "_product"}, 32'(resp_product), 32'(e.p));
            chk({tag, "_timeout"}, 32'(resp_timeout), 32'(e.to));
        end
    endtask

    task automatic run_job(input vec_t v);
        int   b_rdy, b_mrst, b_mstart, b_wait;
        exp_t e;
        mul_lat = v.lat;
        hang    = v.hng;
        req_x[v.id*8 +: 8] = v.x;
        req_y[v.id*8 +: 8] = v.y;
        req_valid[v.id]    = 1'b1;
        b_rdy = n_rdy; b_mrst = n_mrst; b_mstart = n_mstart; b_wait = n_wait;
        wait_grant(v.id);
        e.id = 2'(v.id); e.p = v.p; e.to = v.to;
        sb.push_back(e);
        @(negedge clock);
        req_valid[v.id] = 1'b0;
        chk("clear_mul_reset", 32'(mul_reset), 32'd1);
        chk("clear_mul_x",     32'(mul_x),     32'(v.x));
        @(negedge clock);
        chk("start_pulse", 32'({mul_reset, mul_start}), 32'd1);
        wait_and_check("job");
        @(negedge clock);
        chk("job_accepted", 32'({resp_valid, busy}), 32'd0);
        chk("req_ready_pulses", 32'(n_rdy - b_rdy),       32'd1);
        chk("mul_reset_pulses", 32'(n_mrst - b_mrst),     32'd1);
        chk("mul_start_pulses", 32'(n_mstart - b_mstart), 32'd1);
        chk("wait_cycles",      32'(n_wait - b_wait),     32'(v.wcyc));
    endtask

    vec_t vecs[8];
    int   ord1[5];
    int   ord2[4];

    initial begin
        vecs[0] = '{0, 8'd3,   8'd5,   4,  1'b0, 16'd15,    1'b0, 5};
        vecs[1] = '{2, 8'd255, 8'd255, 4,  1'b0, 16'd65025, 1'b0, 5};
        vecs[2] = '{1, 8'd0,   8'd200, 4,  1'b0, 16'd0,     1'b0, 5};
        vecs[3] = '{3, 8'd17,  8'd13,  4,  1'b0, 16'd221,   1'b0, 5};
        vecs[4] = '{2, 8'd12,  8'd34,  63, 1'b0, 16'd408,   1'b0, 64};
        vecs[5] = '{0, 8'd9,   8'd9,   64, 1'b0, 16'd0,     1'b1, 64};
        vecs[6] = '{1, 8'd5,   8'd6,   4,  1'b1, 16'd0,     1'b1, 64};
        vecs[7] = '{3, 8'd2,   8'd100, 4,  1'b0, 16'd200,   1'b0, 5};
        ord1 = '{0, 1, 2, 3, 0};
        ord2 = '{2, 3, 0, 2};

        // ---- reset state
        repeat (2) @(negedge clock);
        chk("rst_mul_reset",  32'(mul_reset),  32'd1);
        chk("rst_outputs",    32'({mul_start, resp_valid, resp_timeout, busy}), 32'd0);
        chk("rst_data",       32'({mul_x, mul_y, resp_id}), 32'd0);
        chk("rst_product",    32'(resp_product), 32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_mul_reset", 32'(mul_reset), 32'd0);

        // ---- table-driven single jobs
        for (int i = 0; i < 8; i++) run_job(vecs[i]);
        hang = 1'b0; mul_lat = 4;

        // ---- contention: all requesters held from reset
        for (int i = 0; i < 4; i++) begin
            req_x[i*8 +: 8] = 8'(i + 1);
            req_y[i*8 +: 8] = 8'd10;
        end
        req_valid = 4'b1111;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            int   g, want;
            exp_t e;
            if (k == 5) req_valid[1] = 1'b0;
            want = (k < 5) ? ord1[k] : ord2[k-5];
            wait_grant(want);
            g = -1;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            chk("grant_order", 32'(g), 32'(want));
            e.id = 2'(want); e.p = 16'((want + 1) * 10); e.to = 1'b0;
            sb.push_back(e);
            @(negedge clock);
            wait_and_check("contend");
            @(negedge clock);
        end
        req_valid = '0;
        @(negedge clock);

        // ---- backpressure
        begin
            exp_t e;
            int   bad = 0;
            resp_ready = 1'b0;
            req_x[15:8] = 8'd7; req_y[15:8] = 8'd9;
            req_valid[1] = 1'b1;
            wait_grant(1);
            e.id = 2'd1; e.p = 16'd63; e.to = 1'b0;
            sb.push_back(e);
            @(negedge clock);
            req_valid[1] = 1'b0;
            wait_and_check("bp");
            req_x[31:24] = 8'd4; req_y[31:24] = 8'd4;
            req_valid[3] = 1'b1;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_product !== 16'd63 ||
                    mul_x !== 8'd7 || req_ready !== 4'b0) bad++;
                @(negedge clock);
            end
            chk("bp_stable", 32'(bad), 32'd0);
            resp_ready = 1'b1;
            @(negedge clock);
            chk("bp_accept_first", 32'(resp_valid), 32'd0);
            #1;
            chk("bp_next_grant", 32'(req_ready), 32'b1000);
            req_valid[3] = 1'b0;
            #1;
            @(negedge clock);
            chk("bp_withdrawn", 32'(busy), 32'd0);
        end

        // ---- reset in the middle of WAIT
        begin
            exp_t e;
            int   seen = 0;
            hang = 1'b1;
            req_x[7:0] = 8'd11; req_y[7:0] = 8'd11;
            req_valid[0] = 1'b1;
            wait_grant(0);
            e.id = 2'd0; e.p = 16'd121; e.to = 1'b0;
            sb.push_back(e);
            @(negedge clock);
            req_valid[0] = 1'b0;
            repeat (6) @(negedge clock);
            chk("midwait_busy", 32'(busy), 32'd1);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            chk("midrst_state", 32'({busy, mul_reset, resp_valid, mul_start}), 32'b0100);
            chk("midrst_req_ready", 32'(req_ready), 32'd0);
            sb.delete();
            for (int c = 0; c < 80; c++) begin
                if (resp_valid) seen++;
                @(negedge clock);
            end
            chk("dropped_no_resp", 32'(seen), 32'd0);
            hang = 1'b0;
        end
        run_job('{2, 8'd6, 8'd7, 4, 1'b0, 16'd42, 1'b0, 5});
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1);
    end

endmodule : tb_mul_arbiter
`default_nettype wire
